// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// One subtract (P + ~B + 1) per clock, MSB of the dividend first, WIDTH steps.
// Optional feature macro: DIV_ZERO_CHECK_EN. When it is defined, a zero divisor
// takes a one-cycle short path and raises DivByZero. When it is not defined,
// DivByZero is tied low.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  // r_a shifts dividend bits out of the top and quotient bits in at the bottom.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_quot, r_rem;
  logic             r_busy, r_done;

  logic             w_accept, w_step, w_last;
  logic [WIDTH:0]   w_p_sh, w_d;
  logic [WIDTH-1:0] w_p_nxt;
  logic             w_qbit;
`ifdef DIV_ZERO_CHECK_EN
  logic             w_zero_path;
  logic             r_dbz;
`endif

  // One restoring step. A set top bit of D means a borrow, so P is kept.
  // After a restore P < B, so the next partial remainder always fits in WIDTH bits.
  assign w_p_sh  = {r_p, r_a[WIDTH-1]};
  assign w_d     = w_p_sh + ~{1'b0, r_b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_qbit  = ~w_d[WIDTH];
  assign w_p_nxt = w_qbit ? w_d[WIDTH-1:0] : w_p_sh[WIDTH-1:0];

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
    w_zero_path = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
`ifdef DIV_ZERO_CHECK_EN
          if (B == '0) begin
            w_zero_path = 1'b1;
            w_state_nxt = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch and iteration datapath.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_p   <= '0;
      r_cnt <= '0;
    end else if (w_step) begin
      r_a   <= {r_a[WIDTH-2:0], w_qbit};
      r_p   <= w_p_nxt;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Registered status flags, derived from where the FSM is heading.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_CALC);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  // Result registers: hold until the next accepted request reloads them.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_quot <= '0;
      r_rem  <= '0;
    end else if (w_last) begin
      r_quot <= {r_a[WIDTH-2:0], w_qbit};
      r_rem  <= w_p_nxt;
    end
`ifdef DIV_ZERO_CHECK_EN
    else if (w_zero_path) begin
      r_quot <= '1;
      r_rem  <= A;
    end
`endif
  end

`ifdef DIV_ZERO_CHECK_EN
  // Divide-by-zero flag: set by the short path, cleared by a nonzero accept.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)        r_dbz <= 1'b0;
    else if (w_accept) r_dbz <= w_zero_path;
  end
  assign DivByZero = r_dbz;
`else
  assign DivByZero = 1'b0;
`endif

  assign Quotient  = r_quot;
  assign Remainder = r_rem;
  assign Busy      = r_busy;
  assign Done      = r_done;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4), scoreboard driven.
// Honours DIV_ZERO_CHECK_EN so the same bench covers both builds.
module tb_seq_divider;
  localparam int W = 4;

  logic         Clk = 1'b0, Rst_n = 1'b0, Start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [W-1:0] Quotient, Remainder;
  logic         Busy, Done, DivByZero;

  seq_divider #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .A(A), .B(B),
    .Quotient(Quotient), .Remainder(Remainder),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0, n_tot = 0, n_bad = 0, n_done = 0;
  logic prev_done = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Expected result built from integer division; divisor 0 gives all ones / A.
  function automatic exp_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    e.acc = acc;
    e.lat = W;
    e.dbz = 1'b0;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
`ifdef DIV_ZERO_CHECK_EN
      e.lat = 0;
      e.dbz = 1'b1;
`endif
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Scoreboard monitor: every Done pops one expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (Rst_n) begin
      if (Done) begin
        n_done++;
        chk("done_width", prev_done, 0);
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("quotient", Quotient, e.q);
          chk("remainder", Remainder, e.r);
          chk("divbyzero", DivByZero, e.dbz);
          chk("latency", cyc - e.acc, e.lat);
        end
      end
      prev_done = Done;
    end else prev_done = 1'b0;
  end

  // One request; counts Busy cycles until Done, then returns with the DUT in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   busy_n = 0;
    bit   got = 0;
    e = mk(a, b, cyc + 1);
    A = a; B = b; Start = 1'b1;
    sb.push_back(e);
    @(posedge Clk); #1;
    Start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clk);
      if (Done) got = 1;
      else if (Busy) busy_n++;
    end
    chk("done_seen", got, 1);
    chk("busy_cycles", busy_n, e.lat);
    @(posedge Clk); #1;
  endtask

  task automatic check_hold(input string tag, input logic [W-1:0] q, input logic [W-1:0] r);
    repeat (3) @(posedge Clk);
    #1;
    chk({tag, "_q"}, Quotient, q);
    chk({tag, "_r"}, Remainder, r);
    chk({tag, "_done"}, Done, 0);
  endtask

  initial begin
    int d0;
    bit got;
    #1;
    chk("rst_q", Quotient, 0);
    chk("rst_r", Remainder, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_dbz", DivByZero, 0);
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(posedge Clk); #1;

    run_op(13, 4);
    check_hold("hold13", 3, 1);
    run_op(15, 1);
    run_op(7, 9);
    check_hold("hold7", 0, 7);
    run_op(9, 0);
    run_op(10, 3);
    chk("dbz_cleared", DivByZero, 0);

    // A second Start during CALC must be ignored.
    d0 = n_done;
    A = 13; B = 4; Start = 1'b1;
    sb.push_back(mk(13, 4, cyc + 1));
    @(posedge Clk); #1 Start = 1'b0;
    repeat (2) @(posedge Clk);
    #1 A = 2; B = 1; Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    repeat (12) @(posedge Clk);
    #1;
    chk("ignore_dones", n_done - d0, 1);
    chk("ignore_q", Quotient, 3);
    chk("ignore_r", Remainder, 1);

    // Asynchronous reset in the middle of CALC aborts without a Done.
    d0 = n_done;
    A = 13; B = 4; Start = 1'b1;
    sb.push_back(mk(13, 4, cyc + 1));
    @(posedge Clk); #1 Start = 1'b0;
    @(posedge Clk); @(posedge Clk);
    #2 Rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_q", Quotient, 0);
    chk("abort_r", Remainder, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    @(posedge Clk); #1 Rst_n = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    chk("abort_no_done", n_done - d0, 0);
    run_op(6, 3);

    // Start held high: one accept every W+2 cycles.
    A = 14; B = 3; Start = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(mk(14, 3, cyc + 1 + k * (W + 2)));
    repeat (2 * (W + 2) + 1) @(posedge Clk);
    #1 Start = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge Clk); #1;
      if (sb.size() == 0) got = 1;
    end
    chk("held_drained", got, 1);
    repeat (W + 4) @(posedge Clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 want 0");
    $fatal(1, "timeout");
  end
endmodule
